exec_sched: RTL and testbench
=============================

EXEC_SCHED -- requirements
Module: exec_sched

Interface
REQ-001 SHALL have parameter N_UNIT, default 4, number of attached functional units (2..8).
REQ-002 SHALL have parameter LEN_TAG, default 7, physical destination register address width.
REQ-003 SHALL have parameter LEN_DATA, default 32, result width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port order  input  1  issue request from instruction window.
REQ-007 SHALL have port unit_sel  input  N_UNIT  one-hot target unit for the request.
REQ-008 SHALL have port pa_rd_in  input  LEN_TAG  destination tag of the request.
REQ-009 SHALL have port accepted  output  1  request taken this cycle (combinational).
REQ-010 SHALL have port u_order  output  N_UNIT  per-unit issue strobe (combinational).
REQ-011 SHALL have port u_accepted  input  N_UNIT  per-unit accept, same cycle as u_order.
REQ-012 SHALL have port u_done  input  N_UNIT  per-unit one-cycle completion pulse.
REQ-013 SHALL have port u_rd  input  N_UNIT*LEN_DATA  per-unit result, unit i at bits [i*LEN_DATA +: LEN_DATA], valid with u_done[i].
REQ-014 SHALL have port flush  input  1  discard all in-flight and pending results.
REQ-015 SHALL have port wb_valid  output  1  registered write-back strobe.
REQ-016 SHALL have port wb_pa  output  LEN_TAG  write-back tag.
REQ-017 SHALL have port wb_data  output  LEN_DATA  write-back data.
REQ-018 SHALL have port unit_busy  output  N_UNIT  unit i state is not IDLE.

Function
REQ-019 SHALL keep per unit a state IDLE, BUSY, RESULT, DROP, plus tag register and result register.
REQ-020 SHALL drive u_order[i] = order & unit_sel[i] & onehot(unit_sel) & ~flush & issuable[i]; issuable[i] = IDLE, or RESULT granted this cycle.
REQ-021 SHALL drive accepted = OR of (u_order & u_accepted); unit_sel zero or multi-hot -> no u_order, accepted 0.
REQ-022 SHALL on accept capture pa_rd_in into unit tag; next state RESULT if u_done[i] same cycle (capture u_rd), else BUSY.
REQ-023 SHALL in BUSY on u_done[i] capture u_rd slice, go RESULT; ignore u_done[i] in IDLE and RESULT.
REQ-024 SHALL grant one RESULT unit per cycle, round-robin: search from rr_ptr upward modulo N_UNIT; on grant rr_ptr <= granted+1 mod N_UNIT; no grant -> rr_ptr unchanged.
REQ-025 SHALL on grant register wb_valid=1, wb_pa=tag, wb_data=result next edge; granted unit -> IDLE unless reissued same cycle (REQ-020).
REQ-026 SHALL give latency: u_done at cycle t -> earliest wb_valid at t+1; accept with same-cycle done at t -> wb_valid at t+1 if granted.
REQ-027 SHALL hold wb_valid 0 in cycles with no grant; wb_pa/wb_data hold last value.
REQ-028 SHALL on flush: RESULT -> IDLE, BUSY -> DROP, no grant, wb_valid 0 next cycle, accepted 0.
REQ-029 SHALL in DROP on u_done[i] go IDLE without capture; DROP unit not issuable; unit_busy[i]=1.
REQ-030 SHALL treat flush with simultaneous u_done[i] in BUSY as drop (-> IDLE, result discarded).
REQ-031 SHALL guarantee each accepted, non-flushed op produces exactly one wb_valid pulse; no starvation: RESULT unit granted within N_UNIT cycles.

Reset
REQ-032 SHALL on rstn=0 asynchronously set all units IDLE, rr_ptr=0, wb_valid=0, wb_pa=0, wb_data=0, tags/results 0; unit_busy=0.
REQ-033 SHALL discard ops in flight at reset; u_done after reset release to IDLE unit ignored.

Verification
REQ-034 SHALL cover: order, unit_sel=4'b0001, pa=5, u_accepted[0]=u_done[0]=1, u_rd0=0x11 at t -> wb_valid t+1, wb_pa=5, wb_data=0x11.
REQ-035 SHALL cover: units 0,1,2 done same cycle t with tags 1,2,3, rr_ptr=1 -> wb tags 2,3,1 at t+1,t+2,t+3.
REQ-036 SHALL cover: unit_sel=4'b0110 with order -> accepted=0, u_order=0.
REQ-037 SHALL cover: unit 3 BUSY tag 9, flush at t, u_done[3] at t+2 data 0xAA -> no wb_valid for tag 9, unit_busy[3] 1 through t+2, 0 at t+3.
REQ-038 SHALL cover: unit 0 RESULT granted at t with new order to unit 0 accepted at t -> wb_valid at t+1 for old tag, unit_busy[0] stays 1.
REQ-039 SHALL cover: rstn low mid-BUSY on unit 2 -> outputs 0 immediately; u_done[2] after release -> no wb_valid.

Source files
------------

// File: rtl/exec_sched.sv
// ---------------------------------------------------------------------------
// exec_sched -- issue / write-back scheduler for N_UNIT functional units
//
// Purpose:
//   Routes one issue request per cycle from the instruction window to a
//   one-hot selected functional unit. It tracks each unit's outstanding op
//   (destination tag plus result) and arbitrates one result per cycle onto a
//   registered write-back port using a round-robin pointer. A flush discards
//   every pending result. Ops still executing are marked DROP, so their
//   eventual completion pulse is swallowed.
//
// Ports:
//   clk         in   single clock, all state on rising edge
//   rstn        in   asynchronous active-low reset
//   order       in   issue request from instruction window
//   unit_sel    in   [N_UNIT]           one-hot target unit of the request
//   pa_rd_in    in   [LEN_TAG]          destination tag of the request
//   accepted    out  request taken this cycle (combinational)
//   u_order     out  [N_UNIT]           per-unit issue strobe (combinational)
//   u_accepted  in   [N_UNIT]           per-unit accept, same cycle as u_order
//   u_done      in   [N_UNIT]           per-unit one-cycle completion pulse
//   u_rd        in   [N_UNIT*LEN_DATA]  per-unit results, unit i at i*LEN_DATA
//   flush       in   discard all in-flight and pending results
//   wb_valid    out  registered write-back strobe
//   wb_pa       out  [LEN_TAG]          write-back tag (holds when idle)
//   wb_data     out  [LEN_DATA]         write-back data (holds when idle)
//   unit_busy   out  [N_UNIT]           unit state is not IDLE
// ---------------------------------------------------------------------------
module exec_sched #(
  parameter int N_UNIT   = 4,
  parameter int LEN_TAG  = 7,
  parameter int LEN_DATA = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       order,
  input  logic [N_UNIT-1:0]          unit_sel,
  input  logic [LEN_TAG-1:0]         pa_rd_in,
  output logic                       accepted,
  output logic [N_UNIT-1:0]          u_order,
  input  logic [N_UNIT-1:0]          u_accepted,
  input  logic [N_UNIT-1:0]          u_done,
  input  logic [N_UNIT*LEN_DATA-1:0] u_rd,
  input  logic                       flush,
  output logic                       wb_valid,
  output logic [LEN_TAG-1:0]         wb_pa,
  output logic [LEN_DATA-1:0]        wb_data,
  output logic [N_UNIT-1:0]          unit_busy
);

  localparam int PTR_W = (N_UNIT > 1) ? $clog2(N_UNIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_RESULT = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  // Per-unit bookkeeping
  state_t              r_state [N_UNIT];
  logic [LEN_TAG-1:0]  r_tag   [N_UNIT];
  logic [LEN_DATA-1:0] r_res   [N_UNIT];
  logic [PTR_W-1:0]    r_rr_ptr;

  // Registered write-back port
  logic                r_wb_valid;
  logic [LEN_TAG-1:0]  r_wb_pa;
  logic [LEN_DATA-1:0] r_wb_data;

  // Combinational helpers
  logic [LEN_DATA-1:0] w_rd [N_UNIT];
  logic                w_onehot;
  logic [N_UNIT-1:0]   w_req;
  logic [N_UNIT-1:0]   w_fresh;
  logic [N_UNIT-1:0]   w_cand;
  logic [N_UNIT-1:0]   w_gnt;
  logic [N_UNIT-1:0]   w_take;
  logic                w_gnt_vld;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [LEN_TAG-1:0]  w_wb_tag;
  logic [LEN_DATA-1:0] w_wb_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_UNIT; gi++) begin : g_unit
      assign w_rd[gi]      = u_rd[gi*LEN_DATA +: LEN_DATA];
      assign unit_busy[gi] = (r_state[gi] != S_IDLE);
    end
  endgenerate

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign w_onehot = (unit_sel != '0) &&
                    ((unit_sel & (unit_sel - {{(N_UNIT-1){1'b0}}, 1'b1})) == '0);

  // Candidates for write-back this cycle. Besides units already holding a
  // result, a unit whose result arrives this very cycle (BUSY + u_done, or a
  // fresh accept with same-cycle u_done on an IDLE unit) may be granted
  // straight from u_rd. That bypass gives the one-cycle done-to-write-back
  // latency. A fresh accept only counts on an IDLE unit. This keeps the
  // grant independent of the reissue path of a RESULT unit and avoids a
  // combinational loop.
  always_comb begin
    w_req   = '0;
    w_fresh = '0;
    w_cand  = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      w_req[i]   = order & unit_sel[i] & w_onehot & ~flush;
      w_fresh[i] = w_req[i] & (r_state[i] == S_IDLE) & u_accepted[i] & u_done[i];
      w_cand[i]  = ~flush & ((r_state[i] == S_RESULT) |
                             ((r_state[i] == S_BUSY) & u_done[i]) |
                             w_fresh[i]);
    end
  end

  // Round-robin grant: the first candidate at or above r_rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    for (int k = 0; k < N_UNIT; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_UNIT) idx = idx - N_UNIT;
      if (!w_gnt_vld && w_cand[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PTR_W'(idx);
      end
    end
    for (int i = 0; i < N_UNIT; i++) begin
      w_gnt[i] = w_gnt_vld && (int'(w_gnt_idx) == i);
    end
  end

  // Issue strobes. A RESULT unit becomes issuable in the cycle its result is
  // drained. Also selects the write-back source, which is either the stored
  // result or the bypassed live result.
  always_comb begin
    u_order = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      u_order[i] = w_req[i] & ((r_state[i] == S_IDLE) |
                               ((r_state[i] == S_RESULT) & w_gnt[i]));
    end
    w_take   = u_order & u_accepted;
    accepted = |w_take;

    w_wb_tag  = r_tag[w_gnt_idx];
    w_wb_data = r_res[w_gnt_idx];
    if (r_state[w_gnt_idx] != S_RESULT) w_wb_data = w_rd[w_gnt_idx];
    if (r_state[w_gnt_idx] == S_IDLE)   w_wb_tag  = pa_rd_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_UNIT; i++) begin
        r_state[i] <= S_IDLE;
        r_tag[i]   <= '0;
        r_res[i]   <= '0;
      end
      r_rr_ptr   <= '0;
      r_wb_valid <= 1'b0;
      r_wb_pa    <= '0;
      r_wb_data  <= '0;
    end else begin
      // Write-back stage
      if (w_gnt_vld) begin
        r_wb_valid <= 1'b1;
        r_wb_pa    <= w_wb_tag;
        r_wb_data  <= w_wb_data;
        r_rr_ptr   <= (int'(w_gnt_idx) == N_UNIT - 1) ? '0 : w_gnt_idx + PTR_W'(1);
      end else begin
        r_wb_valid <= 1'b0;
      end

      // Per-unit state
      for (int i = 0; i < N_UNIT; i++) begin
        if (flush) begin
          // Executing ops are dropped. A completion in the flush cycle
          // itself just retires the unit, without capturing a result.
          case (r_state[i])
            S_RESULT: r_state[i] <= S_IDLE;
            S_BUSY:   r_state[i] <= u_done[i] ? S_IDLE : S_DROP;
            S_DROP:   if (u_done[i]) r_state[i] <= S_IDLE;
            default:  r_state[i] <= r_state[i];
          endcase
        end else if (w_take[i]) begin
          r_tag[i] <= pa_rd_in;
          if (u_done[i]) begin
            r_res[i] <= w_rd[i];
            // Only a fresh accept on an IDLE unit can have been drained in
            // this cycle. A reissued RESULT unit was granted for its old op.
            r_state[i] <= (w_gnt[i] && (r_state[i] == S_IDLE)) ? S_IDLE : S_RESULT;
          end else begin
            r_state[i] <= S_BUSY;
          end
        end else begin
          case (r_state[i])
            S_BUSY: if (u_done[i]) begin
              r_res[i]   <= w_rd[i];
              r_state[i] <= w_gnt[i] ? S_IDLE : S_RESULT;
            end
            S_RESULT: if (w_gnt[i]) r_state[i] <= S_IDLE;
            S_DROP:   if (u_done[i]) r_state[i] <= S_IDLE;
            default:  r_state[i] <= r_state[i];
          endcase
        end
      end
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_pa    = r_wb_pa;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_exec_sched.sv
// ---------------------------------------------------------------------------
// tb_exec_sched -- scoreboard bench for exec_sched
//
// The driver applies one set of inputs per cycle. A reference model of the
// units then predicts the combinational outputs and next cycle's write-back
// port, and the prediction is pushed into a queue. A separate monitor pops
// one entry per cycle and compares it with the registered write-back port.
// Directed scenarios run first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_exec_sched;
  localparam int N  = 4;
  localparam int TW = 7;
  localparam int DW = 32;

  localparam int S_IDLE = 0, S_BUSY = 1, S_RES = 2, S_DROP = 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            order = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    unit_sel = '0;
  logic [N-1:0]    u_accepted = '0;
  logic [N-1:0]    u_done = '0;
  logic [TW-1:0]   pa_rd_in = '0;
  logic [N*DW-1:0] u_rd = '0;
  logic            accepted;
  logic [N-1:0]    u_order;
  logic [N-1:0]    unit_busy;
  logic            wb_valid;
  logic [TW-1:0]   wb_pa;
  logic [DW-1:0]   wb_data;

  exec_sched #(.N_UNIT(N), .LEN_TAG(TW), .LEN_DATA(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .order      (order),
    .unit_sel   (unit_sel),
    .pa_rd_in   (pa_rd_in),
    .accepted   (accepted),
    .u_order    (u_order),
    .u_accepted (u_accepted),
    .u_done     (u_done),
    .u_rd       (u_rd),
    .flush      (flush),
    .wb_valid   (wb_valid),
    .wb_pa      (wb_pa),
    .wb_data    (wb_data),
    .unit_busy  (unit_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  in_rst  = 1'b1;

  // Reference model: what each unit currently holds, plus the held wb values
  int            m_st  [N];
  logic [TW-1:0] m_tag [N];
  logic [DW-1:0] m_dat [N];
  int            m_ptr;
  logic [TW-1:0] m_wb_tag;
  logic [DW-1:0] m_wb_dat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i]  = S_IDLE;
      m_tag[i] = '0;
      m_dat[i] = '0;
    end
    m_ptr    = 0;
    m_wb_tag = '0;
    m_wb_dat = '0;
  endtask

  function automatic logic [N*DW-1:0] rd1(input int i, input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    r = '0;
    r[i*DW +: DW] = v;
    return r;
  endfunction

  // One clock cycle: drive, check combinational outputs, predict, update model
  task automatic cycle(input logic o, input logic [N-1:0] sel, input logic [TW-1:0] pa,
                       input logic [N-1:0] acc, input logic [N-1:0] dn,
                       input logic [N*DW-1:0] rd, input logic fl);
    bit           req;
    int           s;
    int           g;
    int           st;
    int           i;
    bit           avail;
    logic [N-1:0] exp_uo;
    logic [N-1:0] exp_busy;
    wb_t          e;
    @(posedge clk);
    #1;
    order = o; unit_sel = sel; pa_rd_in = pa; u_accepted = acc;
    u_done = dn; u_rd = rd; flush = fl;
    #2;
    req = o && !fl && ($countones(sel) == 1);
    s = 0;
    for (int k = 0; k < N; k++) if (sel[k]) s = k;
    exp_busy = '0;
    for (int k = 0; k < N; k++) exp_busy[k] = (m_st[k] != S_IDLE);

    // Which unit's result goes out next: first available from the pointer
    g = -1;
    if (!fl) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        avail = (m_st[i] == S_RES) || (m_st[i] == S_BUSY && dn[i]) ||
                (req && i == s && m_st[i] == S_IDLE && acc[i] && dn[i]);
        if (g < 0 && avail) g = i;
      end
    end
    exp_uo = '0;
    if (req && (m_st[s] == S_IDLE || (m_st[s] == S_RES && g == s))) exp_uo[s] = 1'b1;

    chk("u_order", 64'(u_order), 64'(exp_uo));
    chk("accepted", 64'(accepted), 64'(|(exp_uo & acc)));
    chk("unit_busy", 64'(unit_busy), 64'(exp_busy));

    if (g >= 0) begin
      if (m_st[g] == S_RES) begin
        m_wb_tag = m_tag[g];
        m_wb_dat = m_dat[g];
      end else if (m_st[g] == S_BUSY) begin
        m_wb_tag = m_tag[g];
        m_wb_dat = rd[g*DW +: DW];
      end else begin
        m_wb_tag = pa;
        m_wb_dat = rd[g*DW +: DW];
      end
    end
    e.v = (g >= 0);
    e.tag = m_wb_tag;
    e.data = m_wb_dat;
    exp_q.push_back(e);

    for (int k = 0; k < N; k++) begin
      st = m_st[k];
      if (fl) begin
        if (st == S_RES) m_st[k] = S_IDLE;
        else if (st == S_BUSY) m_st[k] = dn[k] ? S_IDLE : S_DROP;
        else if (st == S_DROP && dn[k]) m_st[k] = S_IDLE;
      end else if (exp_uo[k] && acc[k]) begin
        m_tag[k] = pa;
        if (dn[k]) begin
          m_dat[k] = rd[k*DW +: DW];
          m_st[k]  = (st == S_IDLE && g == k) ? S_IDLE : S_RES;
        end else begin
          m_st[k] = S_BUSY;
        end
      end else if (st == S_BUSY && dn[k]) begin
        m_dat[k] = rd[k*DW +: DW];
        m_st[k]  = (g == k) ? S_IDLE : S_RES;
      end else if (st == S_RES && g == k) begin
        m_st[k] = S_IDLE;
      end else if (st == S_DROP && dn[k]) begin
        m_st[k] = S_IDLE;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % N;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic issue(input int u, input logic [TW-1:0] tag);
    logic [N-1:0] sel;
    sel = '0;
    sel[u] = 1'b1;
    cycle(1'b1, sel, tag, sel, '0, '0, 1'b0);
  endtask

  // Reset asserted between clock edges; outputs must clear immediately
  task automatic mid_reset();
    @(posedge clk);
    #1;
    order = 1'b0; unit_sel = '0; pa_rd_in = '0; u_accepted = '0;
    u_done = '0; u_rd = '0; flush = 1'b0;
    #2;
    rstn = 1'b0;
    in_rst = 1'b1;
    exp_q.delete();
    m_reset();
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'(0));
    chk("rst_wb_pa", 64'(wb_pa), 64'(0));
    chk("rst_wb_data", 64'(wb_data), 64'(0));
    chk("rst_unit_busy", 64'(unit_busy), 64'(0));
    @(posedge clk);
    #3;
    rstn = 1'b1;
    #1;
    in_rst = 1'b0;
  endtask

  // Monitor: one expected write-back port state per cycle
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!in_rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_wb_valid", 64'(wb_valid), 64'(e.v));
        chk("sb_wb_pa", 64'(wb_pa), 64'(e.tag));
        chk("sb_wb_data", 64'(wb_data), 64'(e.data));
      end
    end
  end

  initial begin
    logic [N-1:0]    sel;
    logic [N-1:0]    dn;
    logic [N*DW-1:0] rd;
    int              r;

    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wb_valid", 64'(wb_valid), 64'(0));
    chk("reset_wb_pa", 64'(wb_pa), 64'(0));
    chk("reset_wb_data", 64'(wb_data), 64'(0));
    chk("reset_unit_busy", 64'(unit_busy), 64'(0));
    chk("reset_accepted", 64'(accepted), 64'(0));
    #2;
    rstn = 1'b1;
    in_rst = 1'b0;

    // Immediate completion on unit 0 appears on write-back the next cycle
    cycle(1'b1, 4'b0001, 7'd5, 4'b0001, 4'b0001, rd1(0, 32'h11), 1'b0);
    idle(1);
    chk("imm_wb_valid", 64'(wb_valid), 64'(1));
    chk("imm_wb_pa", 64'(wb_pa), 64'(5));
    chk("imm_wb_data", 64'(wb_data), 64'(32'h11));

    // Three results in one cycle with the pointer at 1: tags 2, 3, 1
    issue(0, 7'd1);
    issue(1, 7'd2);
    issue(2, 7'd3);
    cycle(1'b0, '0, '0, '0, 4'b0111,
          rd1(0, 32'hA0) | rd1(1, 32'hA1) | rd1(2, 32'hA2), 1'b0);
    idle(1);
    chk("rr_first", 64'(wb_pa), 64'(2));
    chk("rr_first_data", 64'(wb_data), 64'(32'hA1));
    idle(1);
    chk("rr_second", 64'(wb_pa), 64'(3));
    idle(1);
    chk("rr_third", 64'(wb_pa), 64'(1));
    chk("rr_third_v", 64'(wb_valid), 64'(1));
    idle(1);
    chk("rr_drained", 64'(wb_valid), 64'(0));
    chk("rr_hold_pa", 64'(wb_pa), 64'(1));

    // Multi-hot select is refused
    cycle(1'b1, 4'b0110, 7'd7, 4'b1111, '0, '0, 1'b0);
    chk("multihot_acc", 64'(accepted), 64'(0));
    chk("multihot_uo", 64'(u_order), 64'(0));

    // Flush while unit 3 is busy: its late completion is swallowed
    issue(3, 7'd9);
    idle(1);
    cycle(1'b0, '0, '0, '0, '0, '0, 1'b1);
    chk("drop_busy_t", 64'(unit_busy[3]), 64'(1));
    idle(1);
    chk("drop_busy_t1", 64'(unit_busy[3]), 64'(1));
    chk("drop_wb_t1", 64'(wb_valid), 64'(0));
    cycle(1'b0, '0, '0, '0, 4'b1000, rd1(3, 32'hAA), 1'b0);
    chk("drop_busy_t2", 64'(unit_busy[3]), 64'(1));
    idle(1);
    chk("drop_busy_t3", 64'(unit_busy[3]), 64'(0));
    chk("drop_no_wb", 64'(wb_valid), 64'(0));

    // Unit 0 reissued in the cycle its pending result is drained
    issue(0, 7'd20);
    issue(1, 7'd21);
    cycle(1'b0, '0, '0, '0, 4'b0011, rd1(0, 32'h200) | rd1(1, 32'h210), 1'b0);
    cycle(1'b1, 4'b0001, 7'd22, 4'b0001, '0, '0, 1'b0);
    chk("reissue_acc", 64'(accepted), 64'(1));
    chk("reissue_uo", 64'(u_order), 64'(4'b0001));
    chk("reissue_prev_wb", 64'(wb_pa), 64'(21));
    idle(1);
    chk("reissue_wb_pa", 64'(wb_pa), 64'(20));
    chk("reissue_wb_data", 64'(wb_data), 64'(32'h200));
    chk("reissue_busy", 64'(unit_busy[0]), 64'(1));
    cycle(1'b0, '0, '0, '0, 4'b0001, rd1(0, 32'h220), 1'b0);
    idle(1);
    chk("reissue_new_pa", 64'(wb_pa), 64'(22));

    // Reset in the middle of an op on unit 2; its late completion is ignored
    issue(2, 7'd30);
    idle(1);
    mid_reset();
    cycle(1'b0, '0, '0, '0, 4'b0100, rd1(2, 32'h55), 1'b0);
    idle(1);
    chk("post_rst_no_wb", 64'(wb_valid), 64'(0));
    chk("post_rst_busy", 64'(unit_busy), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 350) mid_reset();
      r = $urandom_range(0, 9);
      sel = '0;
      if (r == 1) sel = N'($urandom);
      else if (r != 0) sel[$urandom_range(0, N-1)] = 1'b1;
      dn = '0;
      rd = '0;
      for (int k = 0; k < N; k++) begin
        if (m_st[k] == S_BUSY || m_st[k] == S_DROP) dn[k] = ($urandom_range(0, 2) == 0);
        else dn[k] = ($urandom_range(0, 7) == 0);
        rd[k*DW +: DW] = $urandom;
      end
      cycle($urandom_range(0, 3) != 0, sel, TW'($urandom), N'($urandom), dn, rd,
            $urandom_range(0, 24) == 0);
    end
    idle(2);

    @(posedge clk);
    #3;
    chk("sb_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
